// File: rtl/debug_bus_router.sv
// Debug bus router: decodes the top address bits of a debug read, forwards it to one slot and
// always returns a response to the master (slave data, or ERR_DATA on unmapped/stale/timeout).
module debug_bus_router #(
    parameter int unsigned SEL_BITS = 2,
    localparam int unsigned NSLAVE = 2 ** SEL_BITS,
    parameter logic [NSLAVE-1:0] SLAVE_MASK = 4'b0001,
    parameter logic [15:0] TIMEOUT = 16'd1000,
    parameter logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             m_addr,
    input  logic                   m_start,
    output logic [63:0]            m_data,
    output logic                   m_available,
    input  logic                   m_accepted,
    output logic [7:0]             s_addr,
    output logic [NSLAVE-1:0]      s_start,
    input  logic [64*NSLAVE-1:0]   s_data,
    input  logic [NSLAVE-1:0]      s_available,
    output logic [NSLAVE-1:0]      s_accepted,
    output logic                   busy,
    output logic [7:0]             timeout_count,
    output logic [1:0]             dbg_state
);

    // Handshakes: m_start / s_start / s_accepted are single-cycle pulses. s_available[i] is held
    // by slot i until it sees s_accepted[i]; m_available is held until the master pulses
    // m_accepted, which is only honoured in RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_BITS-1:0]   sel_q, sel_d;
    logic [7:0]            addr_q, addr_d;
    logic [63:0]           m_data_q, m_data_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [NSLAVE-1:0]     start_q, start_d;
    logic [NSLAVE-1:0]     acc_q, acc_d;
    logic [NSLAVE-1:0]     stale_q, stale_d;
    logic [7:0]            tcnt_q, tcnt_d;

    logic [SEL_BITS-1:0]   req_sel;
    logic [63:0]           slot_data;

    assign req_sel   = m_addr[7 -: SEL_BITS];
    assign slot_data = s_data[{sel_q, 6'd0} +: 64];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            addr_q   <= '0;
            m_data_q <= '0;
            cnt_q    <= '0;
            start_q  <= '0;
            acc_q    <= '0;
            stale_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            m_data_q <= m_data_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            acc_q    <= acc_d;
            stale_q  <= stale_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        m_data_d = m_data_q;
        cnt_d    = cnt_q;
        start_d  = '0;
        // A stale slot that finally answers is acknowledged and forgotten, whatever the state.
        acc_d    = stale_q & s_available;
        stale_d  = stale_q & ~s_available;
        tcnt_d   = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (m_start) begin
                    if (SLAVE_MASK[req_sel] && !stale_q[req_sel]) begin
                        addr_d           = m_addr;
                        sel_d            = req_sel;
                        start_d[req_sel] = 1'b1;
                        cnt_d            = TIMEOUT;
                        state_d          = ST_WAIT;
                    end else begin
                        m_data_d = ERR_DATA;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Checked before expiry so a response in the final cycle still wins.
                if (s_available[sel_q]) begin
                    m_data_d     = slot_data;
                    acc_d[sel_q] = 1'b1;
                    state_d      = ST_RESP;
                end else if (cnt_q == 16'd1) begin
                    m_data_d       = ERR_DATA;
                    stale_d[sel_q] = 1'b1;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RESP: begin
                if (m_accepted) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_data        = m_data_q;
    assign m_available   = (state_q == ST_RESP);
    assign s_addr        = addr_q;
    assign s_start       = start_q;
    assign s_accepted    = acc_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_count = tcnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_debug_bus_router.sv
// Directed bench for debug_bus_router with TIMEOUT=8: expected master responses are queued when a
// request is issued and popped when m_available rises.
module tb_debug_bus_router;

    localparam int NS = 4;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        m_addr;
    logic              m_start;
    logic [63:0]       m_data;
    logic              m_available;
    logic              m_accepted;
    logic [7:0]        s_addr;
    logic [NS-1:0]     s_start;
    logic [64*NS-1:0]  s_data;
    logic [NS-1:0]     s_available;
    logic [NS-1:0]     s_accepted;
    logic              busy;
    logic [7:0]        timeout_count;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    debug_bus_router #(
        .SEL_BITS  (2),
        .SLAVE_MASK(4'b0001),
        .TIMEOUT   (16'd8),
        .ERR_DATA  (64'hDEAD_BEEF_DEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_addr       (m_addr),
        .m_start      (m_start),
        .m_data       (m_data),
        .m_available  (m_available),
        .m_accepted   (m_accepted),
        .s_addr       (s_addr),
        .s_start      (s_start),
        .s_data       (s_data),
        .s_available  (s_available),
        .s_accepted   (s_accepted),
        .busy         (busy),
        .timeout_count(timeout_count),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag);
        logic [63:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed=response expected=empty scoreboard", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, m_data, e);
        end
    endtask

    task automatic wait_avail(input string tag, input int max_cyc, output int n);
        n = 0;
        while (m_available !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_arrive"}, 64'(m_available), 64'd1);
    endtask

    task automatic issue(input logic [7:0] a, input logic [63:0] exp);
        m_addr  = a;
        m_start = 1'b1;
        exp_q.push_back(exp);
        tick();
        m_start = 1'b0;
    endtask

    task automatic accept();
        m_accepted = 1'b1;
        tick();
        m_accepted = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_data"}, m_data, 64'd0);
        check({tag, "_m_avail"}, 64'(m_available), 64'd0);
        check({tag, "_s_addr"}, 64'(s_addr), 64'd0);
        check({tag, "_s_start"}, 64'(s_start), 64'd0);
        check({tag, "_s_acc"}, 64'(s_accepted), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_tcnt"}, 64'(timeout_count), 64'd0);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        m_addr      = '0;
        m_start     = 1'b0;
        m_accepted  = 1'b0;
        s_data      = '0;
        s_available = '0;
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Normal read on slot 0, slave answers a few cycles after s_start.
        issue(8'h05, 64'h0123_4567_89AB_CDEF);
        check("norm_s_start", 64'(s_start), 64'h1);
        check("norm_s_addr", 64'(s_addr), 64'h05);
        check("norm_busy", 64'(busy), 64'd1);
        tick();
        check("norm_s_start_pulse", 64'(s_start), 64'h0);
        tick();
        tick();
        s_data[63:0]   = 64'h0123_4567_89AB_CDEF;
        s_available[0] = 1'b1;
        tick();
        check("norm_m_avail", 64'(m_available), 64'd1);
        check("norm_s_acc", 64'(s_accepted), 64'h1);
        check_resp("norm_data");
        tick();
        s_available[0] = 1'b0;
        check("norm_s_acc_pulse", 64'(s_accepted), 64'h0);
        check("norm_hold", 64'(m_available), 64'd1);
        check("norm_data_stable", m_data, 64'h0123_4567_89AB_CDEF);
        accept();
        check("norm_done_avail", 64'(m_available), 64'd0);
        check("norm_done_busy", 64'(busy), 64'd0);

        // Unmapped slot 1.
        issue(8'h45, ERR);
        check("unmap_s_start", 64'(s_start), 64'h0);
        check("unmap_avail", 64'(m_available), 64'd1);
        check_resp("unmap_data");
        check("unmap_tcnt", 64'(timeout_count), 64'd0);
        accept();

        // Timeout on silent slot 0.
        issue(8'h10, ERR);
        wait_avail("to", 20, n);
        check("to_latency", 64'(n), 64'd8);
        check_resp("to_data");
        check("to_tcnt", 64'(timeout_count), 64'd1);
        accept();

        // Stale slot answers immediately with ERR, no s_start.
        issue(8'h00, ERR);
        check("stale_s_start", 64'(s_start), 64'h0);
        check("stale_avail", 64'(m_available), 64'd1);
        check_resp("stale_data");
        check("stale_tcnt", 64'(timeout_count), 64'd1);
        accept();

        // Late response from the stale slot is drained.
        s_data[63:0]   = 64'h1111_2222_3333_4444;
        s_available[0] = 1'b1;
        tick();
        check("drain_ack", 64'(s_accepted), 64'h1);
        check("drain_no_resp", 64'(m_available), 64'd0);
        tick();
        s_available[0] = 1'b0;
        check("drain_pulse", 64'(s_accepted), 64'h0);

        issue(8'h3C, 64'hCAFE_F00D_1234_5678);
        check("post_drain_s_start", 64'(s_start), 64'h1);
        s_data[63:0]   = 64'hCAFE_F00D_1234_5678;
        s_available[0] = 1'b1;
        tick();
        check("post_drain_avail", 64'(m_available), 64'd1);
        check_resp("post_drain_data");
        check("post_drain_s_acc", 64'(s_accepted), 64'h1);
        tick();
        s_available[0] = 1'b0;
        accept();

        // Response arrives in the exact expiry cycle.
        issue(8'h01, 64'hA5A5_5A5A_0F0F_F0F0);
        repeat (7) tick();
        check("race_pre_avail", 64'(m_available), 64'd0);
        s_data[63:0]   = 64'hA5A5_5A5A_0F0F_F0F0;
        s_available[0] = 1'b1;
        tick();
        check("race_avail", 64'(m_available), 64'd1);
        check_resp("race_data");
        check("race_tcnt", 64'(timeout_count), 64'd1);
        check("race_s_acc", 64'(s_accepted), 64'h1);
        tick();
        s_available[0] = 1'b0;
        accept();

        // m_start during WAIT is ignored; stray m_accepted and unselected s_available too.
        issue(8'h22, 64'h0F0F_0F0F_0F0F_0F0F);
        check("ign_first_s_start", 64'(s_start), 64'h1);
        m_addr  = 8'h31;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        check("ign_s_start", 64'(s_start), 64'h0);
        check("ign_s_addr", 64'(s_addr), 64'h22);
        m_accepted     = 1'b1;
        s_available[2] = 1'b1;
        tick();
        m_accepted = 1'b0;
        check("ign_acc_busy", 64'(busy), 64'd1);
        check("ign_acc_avail", 64'(m_available), 64'd0);
        tick();
        s_available[2] = 1'b0;
        check("ign_unsel_ack", 64'(s_accepted), 64'h0);
        s_data[63:0]   = 64'h0F0F_0F0F_0F0F_0F0F;
        s_available[0] = 1'b1;
        tick();
        check("b2b_avail", 64'(m_available), 64'd1);
        check_resp("b2b_data");
        s_available[0] = 1'b0;
        m_accepted     = 1'b1;
        tick();
        m_accepted = 1'b0;
        check("b2b_idle", 64'(m_available), 64'd0);
        issue(8'h07, 64'h0000_0000_0000_0777);
        check("b2b_s_start", 64'(s_start), 64'h1);
        check("b2b_s_addr", 64'(s_addr), 64'h07);
        s_data[63:0]   = 64'h0000_0000_0000_0777;
        s_available[0] = 1'b1;
        tick();
        check_resp("b2b2_data");
        tick();
        s_available[0] = 1'b0;
        accept();

        // Async reset while in WAIT.
        m_addr  = 8'h02;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        check("rst_w_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_wait");
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_w_no_resp", 64'(m_available), 64'd0);

        // Async reset while in RESP.
        m_addr  = 8'h04;
        m_start = 1'b1;
        tick();
        m_start        = 1'b0;
        s_data[63:0]   = 64'h7777_7777_7777_7777;
        s_available[0] = 1'b1;
        tick();
        check("rst_r_avail", 64'(m_available), 64'd1);
        #2 rst = 1'b1;
        s_available[0] = 1'b0;
        #1;
        check_reset_outputs("rst_resp");
        #2 rst = 1'b0;
        tick();

        // Saturation of the timeout counter; each loop drains the stale slot.
        for (int i = 0; i < 254; i++) begin
            issue(8'h00, ERR);
            wait_avail("sat", 20, n);
            check_resp("sat_data");
            accept();
            s_available[0] = 1'b1;
            tick();
            tick();
            s_available[0] = 1'b0;
        end
        check("sat_254", 64'(timeout_count), 64'd254);
        for (int i = 0; i < 6; i++) begin
            issue(8'h00, ERR);
            wait_avail("sat2", 20, n);
            check_resp("sat2_data");
            accept();
            s_available[0] = 1'b1;
            tick();
            tick();
            s_available[0] = 1'b0;
        end
        check("sat_255", 64'(timeout_count), 64'd255);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_bus_router.md
Name: debug_bus_router

Overview:
- Sits directly downstream of w6debug on the 8-bit-address / 64-bit-data debug bus.
- Decodes the top address bits and forwards each read request to one of several debug slaves (regfile on slot 0, future peripherals on the other slots).
- Returns the slave's data to the master; a timeout watchdog and an unmapped-slot check guarantee the master always gets a response.
- One transaction in flight at a time.

Parameters:
- SEL_BITS, 2, number of address MSBs used as slave select; NSLAVE = 2**SEL_BITS.
- SLAVE_MASK, 4'b0001, bit i = 1 means slot i is populated.
- TIMEOUT, 16'd1000, number of cycles in WAIT before an error response is issued; legal range 1..65535.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, data returned on timeout, unmapped slot or stale slot.

Ports:
- clk, in, 1: single clock; all logic is on posedge.
- rst, in, 1: asynchronous active-high reset.
- m_addr, in, 8: master address; sampled only when m_start=1.
- m_start, in, 1: single-cycle request pulse.
- m_data, out, 64: response data; valid while m_available=1.
- m_available, out, 1: response valid to the master.
- m_accepted, in, 1: master consumed the response.
- s_addr, out, 8: latched request address, broadcast to all slots.
- s_start, out, NSLAVE: one-hot request pulse.
- s_data, in, 64*NSLAVE: slot i occupies bits [64*i+63:64*i].
- s_available, in, NSLAVE: per-slot response valid; held by the slave until accepted.
- s_accepted, out, NSLAVE: one-hot single-cycle acknowledge to the slave.
- busy, out, 1: high in any state other than IDLE.
- timeout_count, out, 8: saturating count of timeouts; holds at 255.

Behaviour:
- Reset values: m_data=0, m_available=0, s_addr=0, s_start=0, s_accepted=0, busy=0, timeout_count=0, stale=0, state=IDLE. Reset mid-transaction abandons the transaction with no response.
- sel = m_addr[7:8-SEL_BITS].
- IDLE:
  - m_start=1 with SLAVE_MASK[sel]=1 and stale[sel]=0: latch s_addr=m_addr and sel, pulse s_start[sel] for exactly 1 cycle (the next cycle), load the timeout counter, go to WAIT.
  - m_start=1 with an unmapped or stale slot: m_data=ERR_DATA, go to RESP. No s_start, no counter increment.
- WAIT:
  - s_available[sel]=1: capture s_data[sel] into m_data, pulse s_accepted[sel] for 1 cycle, go to RESP.
  - Counter expires after TIMEOUT cycles without a response: m_data=ERR_DATA, set stale[sel], increment timeout_count (saturating), go to RESP.
  - A response in the same cycle as expiry wins: the data is captured and no timeout is counted.
- RESP:
  - m_available=1 and m_data is stable.
  - m_accepted=1: m_available drops next cycle, go to IDLE.
  - m_accepted asserted in the same cycle as the first RESP cycle is honoured.
- Latency: m_start to s_start = 1 cycle; s_available to m_available = 1 cycle; unmapped m_start to m_available = 1 cycle.
- m_start while busy=1 is ignored. No queueing.
- Stale drain runs in every state:
  - Any slot with stale[i]=1 asserting s_available[i] gets an s_accepted[i] pulse for 1 cycle; its data is discarded and stale[i] clears.
  - Takes priority only on slots that are not the active sel. The active sel is never stale.
- s_available from a slot that is not selected and not stale is ignored; no ack is issued.
- m_accepted outside RESP is ignored.
- s_start and s_accepted are never multi-hot, except when a drain ack coincides with an active ack on a different slot.

Test Plan:
- Normal read: m_addr=0x05, m_start; slot 0 raises s_available with 0x0123456789ABCDEF 3 cycles after s_start -> s_start[0] 1 cycle after m_start, s_addr=0x05, s_accepted[0] pulse, m_data=0x0123456789ABCDEF, m_available held until m_accepted, then busy=0.
- Unmapped slot: m_addr=0x45 (slot 1, mask 0001) -> no s_start; m_available=1 next cycle with m_data=DEADBEEFDEADBEEF; timeout_count stays 0.
- Timeout: TIMEOUT=8, slot 0 silent -> error response exactly 8 cycles after entering WAIT; timeout_count=1. A new request to slot 0 then gets an immediate ERR_DATA response. A late s_available[0] receives one s_accepted[0] pulse and stale clears; the next request to slot 0 completes normally.
- Race: s_available asserted in the exact expiry cycle -> real data is returned and timeout_count is unchanged.
- Back-to-back and ignored start: m_start pulsed during WAIT -> ignored with no second s_start. m_accepted in the first RESP cycle followed by m_start on the next cycle -> new transaction accepted.
- Async reset in WAIT and in RESP: every output returns to its reset value immediately, independent of clk; timeout_count saturation at 255 verified after 260 timeouts.
